iq_slot_allocator: RTL and testbench
====================================

Name: iq_slot_allocator

Overview:
- Allocation (write) side of the issue-queue slot pool; the select/issue side picks ready entries from the same pool.
- Tracks an occupancy mask of SIZE slots and hands out the lowest-index free slot on each allocate handshake.
- Accepts one slot release per cycle by index, decoding it to one-hot to clear the mask; supports a full flush.

Parameters:
- SIZE, 8, number of issue-queue slots; power of two, 2..64.
- IDX_W, $clog2(SIZE), slot index width; derived, do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- alloc_valid  input  1  requester wants one slot this cycle.
- alloc_ready  output  1  at least one free slot exists (registered-state based, no comb path from alloc_valid).
- alloc_idx  output  IDX_W  lowest-index free slot; meaningful only when alloc_ready=1.
- free_valid  input  1  release the slot given by free_idx.
- free_idx  input  IDX_W  slot being released.
- flush  input  1  synchronous clear of all slots.
- occ_mask  output  SIZE  registered occupancy mask, bit i = slot i in use.
- occ_count  output  IDX_W+1  registered number of occupied slots, 0..SIZE.
- full  output  1  occ_count == SIZE.
- empty  output  1  occ_count == 0.
- dbl_free_err  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1): occ_mask=0, occ_count=0, full=0, empty=1, alloc_ready=1, alloc_idx=0, dbl_free_err=0.
- alloc_idx/alloc_ready are combinational from occ_mask only: alloc_ready = ~&occ_mask; alloc_idx = index of lowest 0 bit.
- Allocate fires when alloc_valid && alloc_ready; slot alloc_idx becomes occupied on the next edge (1-cycle latency to occ_mask).
- alloc_valid with alloc_ready=0: no state change; requester holds and retries.
- Free fires when free_valid; bit free_idx cleared on next edge.
- Simultaneous alloc and free in the same cycle: both apply. No bypass: a slot freed in cycle N is allocatable from cycle N+1. Alloc and free never target the same slot in one cycle (allocated slot is free, freed slot is occupied).
- Full + free in same cycle: alloc_ready=0 that cycle; next cycle alloc_ready=1, alloc_idx=freed slot if it is lowest free.
- occ_count next = occ_count + alloc_fire - (free_valid && occ_mask[free_idx]); net zero when both fire. Saturation is impossible by construction.
- Free of an already-free slot: mask unchanged, count unchanged (ignored).
- flush has priority over alloc and free in the same cycle: next state is occ_mask=0, occ_count=0.
- rst asserted mid-operation: immediate clear regardless of clock; in-flight alloc is lost.
- Invariant: occ_count == popcount(occ_mask) every cycle.

Optional Feature:
- Macro IQ_ALLOC_DBL_FREE_CHECK_EN.
- Defined: dbl_free_err is set on the edge after free_valid && !occ_mask[free_idx] && !flush; it stays set until rst. Simulation assertion also fires on that condition.
- Undefined: dbl_free_err tied to 0; no checking logic; freeing a free slot is silently ignored.

Decomposition:
- Shared package iq_pkg: IQ_SIZE constant, slot_idx_t (IDX_W-bit index typedef), slot_mask_t (SIZE-bit mask typedef).
- One sub-module: idx_decoder (index -> one-hot SIZE-bit vector with enable), used for the free path and for setting the allocated bit.
- The lowest-free search is a local priority scan in this block.

Test Plan:
- Reset then 8 back-to-back allocs (SIZE=8) -> alloc_idx 0,1,...,7; full=1 and alloc_ready=0 after the 8th edge; occ_count=8.
- Full; free_idx=3 -> next cycle alloc_ready=1, alloc_idx=3; alloc -> full again, occ_count=8.
- occ_mask=8'b0000_0111, alloc and free_idx=1 in same cycle -> slot 3 allocated, slot 1 cleared; occ_mask=8'b0000_1101, count=3; next alloc_idx=1.
- occ_mask=8'hFF, flush with alloc_valid and free_valid=1 -> occ_mask=0, count=0, empty=1, alloc_idx=0.
- Free slot 5 while occ_mask[5]=0 -> mask/count unchanged; dbl_free_err=1 next cycle with IQ_ALLOC_DBL_FREE_CHECK_EN, stays 0 without it.
- Assert rst between clock edges with occ_count=4 -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared issue-queue definitions: pool size and slot index/mask types.
package iq_pkg;

   localparam int IQ_SIZE  = 8;
   localparam int IQ_IDX_W = $clog2(IQ_SIZE);

   typedef logic [IQ_IDX_W-1:0] slot_idx_t;
   typedef logic [IQ_SIZE-1:0]  slot_mask_t;

endpackage

// File: rtl/iq_slot_allocator_idx_decoder.sv
// Slot index to one-hot decoder with enable; all zeros when disabled.
module idx_decoder #(
   parameter int SIZE  = 8,
   parameter int IDX_W = $clog2(SIZE)
) (
   input  logic             i_en,
   input  logic [IDX_W-1:0] i_idx,
   output logic [SIZE-1:0]  o_onehot
);

   // Shift a single set bit into position when enabled.
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot = SIZE'(1) << i_idx;
      end
   end

endmodule

// File: rtl/iq_slot_allocator.sv
// Issue-queue slot allocator: hands out the lowest free slot on each
// alloc handshake, releases one slot per cycle by index, supports flush.
// Optional double-free detection is built when IQ_ALLOC_DBL_FREE_CHECK_EN
// is defined; otherwise dbl_free_err is tied low.
module iq_slot_allocator
   import iq_pkg::*;
#(
   parameter int SIZE  = IQ_SIZE,
   parameter int IDX_W = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   output logic [IDX_W-1:0] alloc_idx,
   input  logic             free_valid,
   input  logic [IDX_W-1:0] free_idx,
   input  logic             flush,
   output logic [SIZE-1:0]  occ_mask,
   output logic [IDX_W:0]   occ_count,
   output logic             full,
   output logic             empty,
   output logic             dbl_free_err
);

   logic [SIZE-1:0]  r_occ_mask;
   logic [IDX_W:0]   r_occ_count;
   logic [IDX_W-1:0] w_alloc_idx;
   logic             w_alloc_ready;
   logic             w_alloc_fire;
   logic             w_free_hit;
   logic [SIZE-1:0]  w_alloc_oh;
   logic [SIZE-1:0]  w_free_oh;
   logic [SIZE-1:0]  w_mask_nxt;
   logic [IDX_W:0]   w_count_nxt;

   assign w_alloc_ready = ~&r_occ_mask;
   assign w_alloc_fire  = alloc_valid & w_alloc_ready;
   assign w_free_hit    = free_valid & r_occ_mask[free_idx];

   // Priority scan for the lowest-index free slot; scanning downward lets
   // the last assignment win.
   always_comb begin
      w_alloc_idx = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (!r_occ_mask[i]) begin
            w_alloc_idx = IDX_W'(i);
         end
      end
   end

   idx_decoder #(.SIZE(SIZE), .IDX_W(IDX_W)) u_dec_alloc (
      .i_en     (w_alloc_fire),
      .i_idx    (w_alloc_idx),
      .o_onehot (w_alloc_oh)
   );

   idx_decoder #(.SIZE(SIZE), .IDX_W(IDX_W)) u_dec_free (
      .i_en     (free_valid),
      .i_idx    (free_idx),
      .o_onehot (w_free_oh)
   );

   // Next occupancy: alloc and free never target the same slot, so set and
   // clear can be applied together. Freeing a free slot clears a zero bit.
   always_comb begin
      w_mask_nxt  = (r_occ_mask | w_alloc_oh) & ~w_free_oh;
      w_count_nxt = r_occ_count + (IDX_W+1)'(w_alloc_fire)
                                - (IDX_W+1)'(w_free_hit);
   end

   // Occupancy state; flush overrides any same-cycle alloc or free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ_mask  <= '0;
         r_occ_count <= '0;
      end else if (flush) begin
         r_occ_mask  <= '0;
         r_occ_count <= '0;
      end else begin
         r_occ_mask  <= w_mask_nxt;
         r_occ_count <= w_count_nxt;
      end
   end

`ifdef IQ_ALLOC_DBL_FREE_CHECK_EN
   logic r_dbl_free_err;
   logic w_dbl_free;

   assign w_dbl_free = free_valid & ~r_occ_mask[free_idx] & ~flush;

   // Sticky double-free flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dbl_free_err <= 1'b0;
      end else if (w_dbl_free) begin
         r_dbl_free_err <= 1'b1;
      end
   end

   assign dbl_free_err = r_dbl_free_err;

`ifndef SYNTHESIS
   // Flag a release of a slot that is not occupied.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!w_dbl_free)
            else $warning("iq_slot_allocator: release of unoccupied slot %0d", free_idx);
      end
   end
`endif
`else
   assign dbl_free_err = 1'b0;
`endif

   assign alloc_ready = w_alloc_ready;
   assign alloc_idx   = w_alloc_idx;
   assign occ_mask    = r_occ_mask;
   assign occ_count   = r_occ_count;
   assign full        = (r_occ_count == (IDX_W+1)'(SIZE));
   assign empty       = (r_occ_count == '0);

endmodule

// File: tb/tb_iq_slot_allocator.sv
// Directed bench for iq_slot_allocator (SIZE=8).
module tb_iq_slot_allocator;

   logic       clk;
   logic       rst;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [2:0] alloc_idx;
   logic       free_valid;
   logic [2:0] free_idx;
   logic       flush;
   logic [7:0] occ_mask;
   logic [3:0] occ_count;
   logic       full;
   logic       empty;
   logic       dbl_free_err;

   int n_chk;
   int n_pass;

`ifdef IQ_ALLOC_DBL_FREE_CHECK_EN
   localparam logic EXP_DBL = 1'b1;
`else
   localparam logic EXP_DBL = 1'b0;
`endif

   iq_slot_allocator #(.SIZE(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_ready  (alloc_ready),
      .alloc_idx    (alloc_idx),
      .free_valid   (free_valid),
      .free_idx     (free_idx),
      .flush        (flush),
      .occ_mask     (occ_mask),
      .occ_count    (occ_count),
      .full         (full),
      .empty        (empty),
      .dbl_free_err (dbl_free_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mask"},  32'(occ_mask),     32'h00);
      chk({tag, "_count"}, 32'(occ_count),    32'd0);
      chk({tag, "_full"},  32'(full),         32'd0);
      chk({tag, "_empty"}, 32'(empty),        32'd1);
      chk({tag, "_ready"}, 32'(alloc_ready),  32'd1);
      chk({tag, "_idx"},   32'(alloc_idx),    32'd0);
      chk({tag, "_dbl"},   32'(dbl_free_err), 32'd0);
   endtask

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      rst         = 1'b1;
      alloc_valid = 1'b0;
      free_valid  = 1'b0;
      free_idx    = 3'd0;
      flush       = 1'b0;
      #1;
      chk_reset_vals("rst");
      tick();
      tick();
      rst = 1'b0;

      // Eight back-to-back allocations fill the pool in index order.
      alloc_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fill_idx%0d", i), 32'(alloc_idx), 32'(i));
         chk($sformatf("fill_rdy%0d", i), 32'(alloc_ready), 32'd1);
         tick();
      end
      alloc_valid = 1'b0;
      chk("full_flag",  32'(full),        32'd1);
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(occ_count),   32'd8);
      chk("full_mask",  32'(occ_mask),    32'hFF);

      // Requesting while full changes nothing.
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      chk("hold_mask",  32'(occ_mask),  32'hFF);
      chk("hold_count", 32'(occ_count), 32'd8);

      // Release slot 3 while full; it becomes allocatable next cycle.
      free_valid = 1'b1;
      free_idx   = 3'd3;
      chk("frfull_ready_now", 32'(alloc_ready), 32'd0);
      tick();
      free_valid = 1'b0;
      chk("frfull_ready", 32'(alloc_ready), 32'd1);
      chk("frfull_idx",   32'(alloc_idx),   32'd3);
      chk("frfull_count", 32'(occ_count),   32'd7);
      chk("frfull_mask",  32'(occ_mask),    32'hF7);
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      chk("refill_full",  32'(full),      32'd1);
      chk("refill_count", 32'(occ_count), 32'd8);

      // Flush wins over simultaneous alloc and free.
      flush       = 1'b1;
      alloc_valid = 1'b1;
      free_valid  = 1'b1;
      free_idx    = 3'd2;
      tick();
      flush       = 1'b0;
      alloc_valid = 1'b0;
      free_valid  = 1'b0;
      chk("flush_mask",  32'(occ_mask),  32'h00);
      chk("flush_count", 32'(occ_count), 32'd0);
      chk("flush_empty", 32'(empty),     32'd1);
      chk("flush_idx",   32'(alloc_idx), 32'd0);

      // Build mask 0000_0111.
      alloc_valid = 1'b1;
      repeat (3) tick();
      alloc_valid = 1'b0;
      chk("pre_mask", 32'(occ_mask), 32'h07);

      // Simultaneous alloc (slot 3) and free (slot 1).
      alloc_valid = 1'b1;
      free_valid  = 1'b1;
      free_idx    = 3'd1;
      chk("simul_idx_now", 32'(alloc_idx), 32'd3);
      tick();
      alloc_valid = 1'b0;
      free_valid  = 1'b0;
      chk("simul_mask",  32'(occ_mask),  32'h0D);
      chk("simul_count", 32'(occ_count), 32'd3);
      chk("simul_idx",   32'(alloc_idx), 32'd1);

      // Release of unoccupied slot 5 is ignored (and flagged when enabled).
      free_valid = 1'b1;
      free_idx   = 3'd5;
      tick();
      free_valid = 1'b0;
      chk("dfree_mask",  32'(occ_mask),     32'h0D);
      chk("dfree_count", 32'(occ_count),    32'd3);
      chk("dfree_err",   32'(dbl_free_err), 32'(EXP_DBL));
      tick();
      chk("dfree_sticky", 32'(dbl_free_err), 32'(EXP_DBL));

      // Reach count 4, then assert reset between edges.
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      chk("pre_rst_count", 32'(occ_count), 32'd4);
      chk("pre_rst_mask",  32'(occ_mask),  32'h0F);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
